// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU multiplier arbiter: operand width,
// arbiter state encoding and a few well-known single-precision constants.
package fpu_pkg;

  localparam int FP_W = 32;

  // Arbiter sequencing states; encoding is fixed so it can be probed in debug.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SEND_A  = 3'd2,
    SEND_B  = 3'd3,
    WAIT_Z  = 3'd4,
    RETURN  = 3'd5
  } arb_state_t;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F800000;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// found when searching upward from ptr and wrapping past N-1 to 0.
module rr_pick
  import fpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_W = N[IDX_W:0];

  logic [2*N-1:0]   w_dbl;
  logic [2*N-1:0]   w_rot_full;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_wrap;

  // Rotating a doubled copy right by ptr puts requester ptr at bit 0.
  assign w_dbl      = {req, req};
  assign w_rot_full = w_dbl >> ptr;
  assign w_rot      = w_rot_full[N-1:0];
  assign any        = |req;

  // Priority-encode the rotated vector: lowest set bit wins.
  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = i[IDX_W-1:0];
      end
    end
  end

  // Undo the rotation: index = (ptr + offset) mod N.
  assign w_sum  = {1'b0, ptr} + {1'b0, w_off};
  assign w_wrap = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
  assign idx    = w_wrap[IDX_W-1:0];

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one stb/ack single-precision multiplier among
// N requesters. One operation is in flight at a time; grant is non-preemptive.
// Optional statistics ports (ops_done, busy_cycles) are built when the macro
// FPU_MUL_ARB_STATS_EN is defined.
module fpu_mul_arbiter
  import fpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*FP_W-1:0] req_a,
  input  logic [N*FP_W-1:0] req_b,
  input  logic [N-1:0]      req_stb,
  output logic [N-1:0]      req_ack,
  output logic [FP_W-1:0]   rsp_z,
  output logic [N-1:0]      rsp_stb,
  input  logic [N-1:0]      rsp_ack,
  output logic [FP_W-1:0]   mul_a,
  output logic              mul_a_stb,
  input  logic              mul_a_ack,
  output logic [FP_W-1:0]   mul_b,
  output logic              mul_b_stb,
  input  logic              mul_b_ack,
  input  logic [FP_W-1:0]   mul_z,
  input  logic              mul_z_stb,
  output logic              mul_z_ack
`ifdef FPU_MUL_ARB_STATS_EN
  ,
  output logic [15:0]       ops_done,
  output logic [31:0]       busy_cycles
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_grant;
  logic [N-1:0]     r_req_ack;
  logic [N-1:0]     r_rsp_stb;
  logic [FP_W-1:0]  r_rsp_z;
  logic [FP_W-1:0]  r_mul_a;
  logic [FP_W-1:0]  r_mul_b;
  logic             r_mul_a_stb;
  logic             r_mul_b_stb;
  logic             r_mul_z_ack;

  logic [FP_W-1:0]  w_req_a_arr [N];
  logic [FP_W-1:0]  w_req_b_arr [N];
  logic [N-1:0]     w_grant_oh;
  logic [N-1:0]     w_pick_oh;
  logic             w_pick_any;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_ptr_next;
  logic [FP_W-1:0]  w_a_sel;
  logic [FP_W-1:0]  w_b_sel;
  logic             w_ret_done;

  // Unpack the flat operand buses and build one-hot decodes of grant/pick.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign w_req_a_arr[gi] = req_a[FP_W*gi +: FP_W];
      assign w_req_b_arr[gi] = req_b[FP_W*gi +: FP_W];
      assign w_grant_oh[gi]  = (r_grant == IDX_W'(gi));
      assign w_pick_oh[gi]   = (w_pick_idx == IDX_W'(gi));
    end
  endgenerate

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req_stb),
    .ptr (r_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  assign w_a_sel    = w_req_a_arr[r_grant];
  assign w_b_sel    = w_req_b_arr[r_grant];
  // The requester just served drops to lowest priority next time round.
  assign w_ptr_next = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
  assign w_ret_done = (r_state == RETURN) && (|(r_rsp_stb & rsp_ack & w_grant_oh));

  // Main sequencer: arbitration, operand capture and the three multiplier handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_req_ack   <= '0;
      r_rsp_stb   <= '0;
      r_rsp_z     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_a_stb <= 1'b0;
      r_mul_b_stb <= 1'b0;
      r_mul_z_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant   <= w_pick_idx;
            r_req_ack <= w_pick_oh;
            r_state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_req_ack <= '0;
          if (req_stb[r_grant]) begin
            r_mul_a     <= w_a_sel;
            r_mul_b     <= w_b_sel;
            r_mul_a_stb <= 1'b1;
            r_state     <= SEND_A;
          end else begin
            // Requester withdrew before capture: abandon without moving ptr.
            r_state <= IDLE;
          end
        end
        SEND_A: begin
          if (r_mul_a_stb && mul_a_ack) begin
            r_mul_a_stb <= 1'b0;
            r_mul_b_stb <= 1'b1;
            r_state     <= SEND_B;
          end
        end
        SEND_B: begin
          if (r_mul_b_stb && mul_b_ack) begin
            r_mul_b_stb <= 1'b0;
            r_mul_z_ack <= 1'b1;
            r_state     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (r_mul_z_ack && mul_z_stb) begin
            r_rsp_z     <= mul_z;
            r_mul_z_ack <= 1'b0;
            r_rsp_stb   <= w_grant_oh;
            r_state     <= RETURN;
          end
        end
        RETURN: begin
          if (w_ret_done) begin
            r_rsp_stb <= '0;
            r_ptr     <= w_ptr_next;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ack   = r_req_ack;
  assign rsp_stb   = r_rsp_stb;
  assign rsp_z     = r_rsp_z;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_a_stb = r_mul_a_stb;
  assign mul_b_stb = r_mul_b_stb;
  assign mul_z_ack = r_mul_z_ack;

`ifdef FPU_MUL_ARB_STATS_EN
  logic [15:0] r_ops_done;
  logic [31:0] r_busy_cycles;

  // Completed-operation counter (wraps) and non-idle cycle counter (saturates).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops_done    <= '0;
      r_busy_cycles <= '0;
    end else begin
      if (w_ret_done) begin
        r_ops_done <= r_ops_done + 16'd1;
      end
      if ((r_state != IDLE) && (r_busy_cycles != 32'hFFFF_FFFF)) begin
        r_busy_cycles <= r_busy_cycles + 32'd1;
      end
    end
  end

  assign ops_done    = r_ops_done;
  assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter (N=4). A behavioural multiplier with a
// lookup of hand-computed products answers the A/B/Z handshakes; requesters
// and the multiplier are all driven from one process through tick().
`timescale 1ns/1ps
module tb_fpu_mul_arbiter;
  import fpu_pkg::*;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack;
  logic [31:0]     rsp_z;
  logic [N-1:0]    rsp_stb, rsp_ack;
  logic [31:0]     mul_a, mul_b, mul_z;
  logic            mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack, mul_z_stb, mul_z_ack;
`ifdef FPU_MUL_ARB_STATS_EN
  logic [15:0]     ops_done;
  logic [31:0]     busy_cycles;
`endif

  always #5 clk = ~clk;

  fpu_mul_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .rsp_z(rsp_z), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack)
`ifdef FPU_MUL_ARB_STATS_EN
    , .ops_done(ops_done), .busy_cycles(busy_cycles)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_a, m_b;
  int          m_cnt;
  int          mul_lat = 1;
  int          rsp_idx_q [$];
  logic [31:0] rsp_z_q [$];
  int unsigned busy_model;
  int unsigned ops_model;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          ptr_after;
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Hand-computed products for the operand pairs this bench uses.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == FP_ONE) return b;
    if (b == FP_ONE) return a;
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h7F800000 && b == 32'h00000000) return 32'hFFC00000;
    return FP_QNAN;
  endfunction

  // Advance one clock: sample handshakes before the edge, update models after.
  task automatic tick();
    logic [N-1:0] q_x, r_x;
    logic         a_x, b_x, z_x, busy;
    logic [31:0]  rz;
    q_x  = req_stb & req_ack;
    r_x  = rsp_stb & rsp_ack;
    a_x  = mul_a_stb & mul_a_ack;
    b_x  = mul_b_stb & mul_b_ack;
    z_x  = mul_z_stb & mul_z_ack;
    rz   = rsp_z;
    busy = (|req_ack) | mul_a_stb | mul_b_stb | mul_z_ack | (|rsp_stb);
    if (!$onehot0(req_ack)) chk("req_ack_onehot", {28'd0, req_ack}, 32'd0);
    if (!$onehot0(rsp_stb)) chk("rsp_stb_onehot", {28'd0, rsp_stb}, 32'd0);
    @(posedge clk);
    #1;
    if (rst) begin
      mul_a_ack = 1'b1; mul_b_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0;
      m_cnt = 0; busy_model = 0; ops_model = 0;
      rsp_idx_q.delete(); rsp_z_q.delete();
    end else begin
      if (busy) busy_model++;
      req_stb = req_stb & ~q_x;
      for (int i = 0; i < N; i++) begin
        if (r_x[i]) begin
          rsp_idx_q.push_back(i);
          rsp_z_q.push_back(rz);
          ops_model++;
          $display("rsp: requester %0d z=%08h", i, rz);
        end
      end
      if (a_x) begin m_a = mul_a; mul_a_ack = 1'b0; mul_b_ack = 1'b1; end
      if (b_x) begin
        m_b = mul_b; mul_b_ack = 1'b0; m_cnt = mul_lat;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin mul_z = fmul_ref(m_a, m_b); mul_z_stb = 1'b1; end
      end
      if (z_x) begin mul_z_stb = 1'b0; mul_a_ack = 1'b1; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_stb = '0; rsp_ack = '1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_stb[i] = 1'b1;
  endtask

  // Wait (bounded) for the next delivered response.
  task automatic wait_rsp(input string name, output int idx, output logic [31:0] z);
    int t = 0;
    while (rsp_idx_q.size() == 0 && t < 300) begin tick(); t++; end
    if (rsp_idx_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: got no response, required one within 300 cycles", name);
      idx = -1; z = 32'hDEADBEEF;
    end else begin
      idx = rsp_idx_q.pop_front();
      z   = rsp_z_q.pop_front();
    end
  endtask

  initial begin
    int          idx, bad, t;
    logic [31:0] z, z0;
    logic [31:0] vals [4];
    vt[0] = '{req: 2, a: 32'h40000000, b: 32'h40400000, z: 32'h40C00000, ptr_after: 3};
    vt[1] = '{req: 0, a: FP_ONE,       b: 32'h40490FDB, z: 32'h40490FDB, ptr_after: 1};
    vt[2] = '{req: 3, a: 32'hC0000000, b: FP_ONE,       z: 32'hC0000000, ptr_after: 0};
    vt[3] = '{req: 1, a: 32'h40000000, b: 32'h40400000, z: 32'h40C00000, ptr_after: 2};
    vals[0] = 32'h3F000000; vals[1] = 32'h40800000;
    vals[2] = 32'hC1200000; vals[3] = 32'h42C80000;
    req_a = '0; req_b = '0; req_stb = '0; rsp_ack = '1;
    mul_a_ack = 1'b1; mul_b_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0;
    m_a = '0; m_b = '0; m_cnt = 0; busy_model = 0; ops_model = 0;

    // Reset state
    do_reset();
    chk("rst_state", 32'(dut.r_state), 32'd0);
    chk("rst_ptr", 32'(dut.r_ptr), 32'd0);
    chk("rst_req_ack", 32'(req_ack), 32'd0);
    chk("rst_rsp_stb", 32'(rsp_stb), 32'd0);
    chk("rst_rsp_z", rsp_z, 32'd0);
    chk("rst_mul_strobes", {29'd0, mul_a_stb, mul_b_stb, mul_z_ack}, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);

    // Single request on 2, with arbiter latency checks
    issue(2, 32'h40000000, 32'h40400000);
    tick();
    chk("single_req_ack", 32'(req_ack), 32'h4);
    chk("single_mul_a_stb_early", {31'd0, mul_a_stb}, 32'd0);
    tick();
    chk("single_mul_a_stb", {31'd0, mul_a_stb}, 32'd1);
    chk("single_req_ack_drop", 32'(req_ack), 32'd0);
    chk("single_mul_a", mul_a, 32'h40000000);
    chk("single_mul_b", mul_b, 32'h40400000);
    wait_rsp("single", idx, z);
    chk("single_idx", idx, 32'd2);
    chk("single_z", z, 32'h40C00000);
    chk("single_ptr", 32'(dut.r_ptr), 32'd3);
    tick();
    chk("single_rsp_stb_drop", 32'(rsp_stb), 32'd0);
    chk("single_rsp_z_hold", rsp_z, 32'h40C00000);

    // Table of single-requester vectors
    for (int v = 0; v < 4; v++) begin
      issue(vt[v].req, vt[v].a, vt[v].b);
      wait_rsp($sformatf("vec%0d", v), idx, z);
      chk($sformatf("vec%0d_idx", v), idx, vt[v].req);
      chk($sformatf("vec%0d_z", v), z, vt[v].z);
      chk($sformatf("vec%0d_mul_a", v), m_a, vt[v].a);
      chk($sformatf("vec%0d_mul_b", v), m_b, vt[v].b);
      chk($sformatf("vec%0d_ptr", v), 32'(dut.r_ptr), vt[v].ptr_after);
    end

    // Requester withdraws during CAPTURE: back to IDLE, ptr untouched (2)
    issue(0, FP_ONE, FP_ONE);
    tick();
    chk("withdraw_req_ack", 32'(req_ack), 32'h1);
    req_stb[0] = 1'b0;
    tick();
    chk("withdraw_state", 32'(dut.r_state), 32'd0);
    chk("withdraw_req_ack_drop", 32'(req_ack), 32'd0);
    chk("withdraw_no_mul_a_stb", {31'd0, mul_a_stb}, 32'd0);
    chk("withdraw_ptr", 32'(dut.r_ptr), 32'd2);

    // All four at once from reset: served 0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) issue(i, FP_ONE, vals[i]);
    for (int k = 0; k < N; k++) begin
      wait_rsp($sformatf("all4_%0d", k), idx, z);
      chk($sformatf("all4_%0d_idx", k), idx, k);
      chk($sformatf("all4_%0d_z", k), z, vals[k]);
    end

    // Back-pressure on requester 1 while requester 0 waits
    rsp_ack[1] = 1'b0;
    issue(1, FP_ONE, 32'h41000000);
    tick(); tick(); tick();
    issue(0, FP_ONE, 32'h41100000);
    t = 0;
    while (rsp_stb[1] !== 1'b1 && t < 100) begin tick(); t++; end
    chk("bp_rsp_stb_seen", 32'(rsp_stb), 32'h2);
    z0 = rsp_z;
    chk("bp_rsp_z", z0, 32'h41000000);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_stb !== 4'b0010 || rsp_z !== z0 || mul_a_stb !== 1'b0) bad++;
    end
    chk("bp_hold_cycles_bad", bad, 32'd0);
    chk("bp_req0_pending", {31'd0, req_stb[0]}, 32'd1);
    rsp_ack[1] = 1'b1;
    wait_rsp("bp_first", idx, z);
    chk("bp_first_idx", idx, 32'd1);
    chk("bp_first_z", z, 32'h41000000);
    wait_rsp("bp_second", idx, z);
    chk("bp_second_idx", idx, 32'd0);
    chk("bp_second_z", z, 32'h41100000);

    // Wrap-around: move ptr to 3, then requests on 3 and 0
    issue(2, FP_ONE, 32'h3E800000);
    wait_rsp("wrap_setup", idx, z);
    chk("wrap_ptr3", 32'(dut.r_ptr), 32'd3);
    issue(3, FP_ONE, 32'h40E00000);
    issue(0, FP_ONE, 32'h41300000);
    wait_rsp("wrap_a", idx, z);
    chk("wrap_a_idx", idx, 32'd3);
    chk("wrap_a_z", z, 32'h40E00000);
    wait_rsp("wrap_b", idx, z);
    chk("wrap_b_idx", idx, 32'd0);
    chk("wrap_b_z", z, 32'h41300000);
    issue(3, FP_ONE, 32'h41500000);
    wait_rsp("wrap_c", idx, z);
    chk("wrap_c_idx", idx, 32'd3);
    chk("wrap_c_z", z, 32'h41500000);

    // Reset while waiting for Z
    mul_lat = 20;
    issue(1, FP_ONE, 32'h40A00000);
    t = 0;
    while (32'(dut.r_state) != 32'd4 && t < 50) begin tick(); t++; end
    chk("rstz_reached_wait_z", 32'(dut.r_state), 32'd4);
    rst = 1'b1; req_stb = '0;
    tick();
    rst = 1'b0;
    chk("rstz_state", 32'(dut.r_state), 32'd0);
    chk("rstz_strobes", {25'd0, req_ack, mul_a_stb, mul_b_stb, mul_z_ack}, 32'd0);
    chk("rstz_rsp_stb", 32'(rsp_stb), 32'd0);
    chk("rstz_ptr", 32'(dut.r_ptr), 32'd0);
    mul_lat = 1;
    for (int c = 0; c < 25; c++) tick();
    chk("rstz_no_stale_rsp", rsp_idx_q.size(), 32'd0);
    issue(1, 32'h7F800000, 32'h00000000);
    wait_rsp("rstz_reissue", idx, z);
    chk("rstz_reissue_idx", idx, 32'd1);
    chk("rstz_reissue_z", z, 32'hFFC00000);

`ifdef FPU_MUL_ARB_STATS_EN
    // Statistics: five operations after reset
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(k % N, FP_ONE, vals[k % N]);
      wait_rsp($sformatf("stats_%0d", k), idx, z);
    end
    chk("stats_ops_done", 32'(ops_done), 32'd5);
    chk("stats_ops_model", ops_model, 32'd5);
    chk("stats_busy_cycles", busy_cycles, busy_model);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
- Shares one single-precision multiplier among N requesters. The multiplier uses stb/ack handshakes: operand A, then operand B, then result Z.
- Each requester presents an operand pair and later receives its product on a shared result bus with a per-requester strobe.
- Grant is round-robin, non-preemptive, with one operation in flight at a time.
- Sits between the FPU issue logic and the multiplier instance.

Parameters:
- N, 4, number of requesters (1..16).
- IDX_W, $clog2(N) (minimum 1), width of the grant index and the rotation pointer.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; shared with the multiplier instance.
- req_a  in  N*32  operand A per requester; slice i = bits [32*i+31:32*i].
- req_b  in  N*32  operand B per requester, same slicing.
- req_stb  in  N  requester i has a valid operand pair.
- req_ack  out  N  operand pair of requester i captured.
- rsp_z  out  32  product, shared by all requesters.
- rsp_stb  out  N  rsp_z valid for requester i.
- rsp_ack  in  N  requester i accepts rsp_z.
- mul_a  out  32  to multiplier input_a.
- mul_a_stb  out  1  to multiplier input_a_stb.
- mul_a_ack  in  1  from multiplier input_a_ack.
- mul_b  out  32  to multiplier input_b.
- mul_b_stb  out  1  to multiplier input_b_stb.
- mul_b_ack  in  1  from multiplier input_b_ack.
- mul_z  in  32  from multiplier output_z.
- mul_z_stb  in  1  from multiplier output_z_stb.
- mul_z_ack  out  1  to multiplier output_z_ack.

Behaviour:
- Transfer rule on every channel: data moves in the cycle where stb and ack are both high at the clock edge. A requester holds req_stb and its operands stable until acked.
- All outputs are registered. Reset values:
  - state=IDLE, ptr=0, grant=0.
  - req_ack=0, rsp_stb=0, rsp_z=0.
  - mul_a_stb=0, mul_b_stb=0, mul_z_ack=0, mul_a=0, mul_b=0.
- States:
  - IDLE: if any req_stb is set, grant = first set index searching ptr, ptr+1, …, N-1, 0, …, ptr-1. Set req_ack[grant]=1 and go to CAPTURE. Otherwise stay.
  - CAPTURE: if req_stb[grant]=1, latch mul_a and mul_b from that slice, drop req_ack, set mul_a_stb=1, go to SEND_A. If req_stb[grant]=0 (protocol violation), drop req_ack and return to IDLE with ptr unchanged.
  - SEND_A: when mul_a_stb & mul_a_ack, clear mul_a_stb, set mul_b_stb, go to SEND_B.
  - SEND_B: when mul_b_stb & mul_b_ack, clear mul_b_stb, set mul_z_ack, go to WAIT_Z.
  - WAIT_Z: when mul_z_stb & mul_z_ack, rsp_z <= mul_z, clear mul_z_ack, set rsp_stb[grant], go to RETURN.
  - RETURN: when rsp_stb[grant] & rsp_ack[grant], clear rsp_stb. Set ptr = grant+1, wrapping N-1 -> 0. Go to IDLE.
- Arbiter overhead: 2 cycles before mul_a_stb (IDLE, CAPTURE), plus 1 cycle from Z capture to rsp_stb. Multiplier latency adds to this.
- Fairness:
  - No requester waits more than N-1 completed operations once req_stb is high.
  - Requests arriving mid-operation wait until IDLE.
  - The requester just served has lowest priority at the next IDLE.
- N=1: ptr stays 0, grant is always 0.
- At most one bit of req_ack and one bit of rsp_stb is high in any cycle.
- rsp_z holds its value after rsp_stb drops.
- Reset mid-operation: the arbiter returns to IDLE and clears all strobes. No response is delivered for the aborted operation. Requesters re-issue.

Optional Feature:
- Macro: FPU_MUL_ARB_STATS_EN.
- Defined:
  - Adds output port ops_done [15:0].
  - Increments by 1 on each RETURN completion and wraps 0xFFFF -> 0.
  - Also adds output port busy_cycles [31:0], which increments every cycle state != IDLE and saturates at 0xFFFFFFFF.
  - Both reset to 0.
- Undefined: neither port nor their counters exist. Behaviour is otherwise identical.

Decomposition:
- Shared package fpu_pkg:
  - FP_W=32.
  - State enum encoding IDLE=0, CAPTURE=1, SEND_A=2, SEND_B=3, WAIT_Z=4, RETURN=5.
  - Constants FP_QNAN=32'h7FC00000 and FP_ONE=32'h3F800000, for benches.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N], ptr[IDX_W].
  - Outputs: any, idx[IDX_W].
  - Implemented by double-width rotate and priority-encode.

Test Plan:
- Single request: requester 2 sends a=0x40000000, b=0x40400000 -> mul_a/mul_b carry those values; rsp_stb[2] pulses with rsp_z=0x40C00000; ptr becomes 3.
- All four requesting simultaneously from reset, each pair (a=0x3F800000, b=value i) -> grants in order 0,1,2,3, each rsp_z equals its own b. No interleaving: rsp_stb one-hot and in order.
- Back-pressure: hold rsp_ack[1]=0 for 20 cycles -> rsp_stb[1] and rsp_z stay stable; no new mul_a_stb until acked; request 0 pending meanwhile is served next.
- Wrap-around: ptr=3, requests on 3 and 0 -> 3 is served, then 0. Then a request on 3 alone -> served without starvation.
- Reset asserted in WAIT_Z -> next cycle all strobes are 0 and state is IDLE. Re-issuing 0x7F800000 x 0x00000000 returns 0xFFC00000 to the correct requester.
- STATS_EN build, 5 operations -> ops_done=5; busy_cycles equals the count of non-IDLE cycles, checked by a bench model.
